// File: rtl/core_run_ctrl.sv
// Run/halt sequencer for the single-cycle core: gates retirement (core_en) for free run,
// single step, run-N, PC breakpoint and EBREAK halt.
// Latency: core_en is combinational from state/PC/Instr; state, cause, cmd_err and
// halt_evt update on the next CLK edge.
// Backpressure: none. cmd_ready is tied high and every valid command is consumed in its
// cycle. Commands that are illegal in the current state are dropped and flagged on cmd_err.
// Ports:
//   CLK, RST              clock, asynchronous active-low reset
//   cmd_valid/op/arg      command strobe; op 0=HALT 1=RUN 2=STEP 3=RUN_N, arg = count
//   cmd_ready, cmd_err    always-ready; registered drop pulse for RUN/STEP/RUN_N when not halted
//   PC, Instr             current fetch PC and instruction from the core
//   bp_en, bp_addr        PC breakpoint
//   core_en               retire enable to the datapath
//   state, halt_cause     0=HALTED 1=RUNNING 2=STEPPING 3=COUNTING; 0=cmd 1=done 2=bp 3=ebreak
//   halt_evt, retired     first-halted-cycle pulse; free-running retire count
module core_run_ctrl #(
    parameter bit RESET_RUN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    output logic             cmd_ready,
    output logic             cmd_err,
    input  logic [31:0]      PC,
    input  logic [31:0]      Instr,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    output logic             core_en,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic             halt_evt,
    output logic [31:0]      retired
);

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_RUN_N = 2'd3;

    localparam logic [1:0] CAUSE_CMD  = 2'd0;
    localparam logic [1:0] CAUSE_DONE = 2'd1;
    localparam logic [1:0] CAUSE_BP   = 2'd2;
    localparam logic [1:0] CAUSE_EBRK = 2'd3;

    typedef enum logic [1:0] {
        S_HALTED   = 2'd0,
        S_RUNNING  = 2'd1,
        S_STEPPING = 2'd2,
        S_COUNTING = 2'd3
    } run_state_t;

    localparam run_state_t RESET_STATE = RESET_RUN ? S_RUNNING : S_HALTED;

    run_state_t       state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             skip_q, skip_d;
    logic             evt_q, evt_d;
    logic             err_q, err_d;
    logic [31:0]      retired_q;

    logic is_ebreak;
    logic is_bp;
    logic stop;
    logic cmd_halt, cmd_run, cmd_step, cmd_run_n;

    assign is_ebreak = (Instr == EBREAK_INSN);
    assign is_bp     = bp_en & (PC == bp_addr);
    // skip masks the stop condition for the first retire after a resume, so the
    // instruction sitting on a breakpoint/EBREAK executes once instead of re-halting.
    assign stop      = ~skip_q & (is_ebreak | is_bp);
    assign core_en   = (state_q != S_HALTED) & ~stop;

    assign cmd_halt  = cmd_valid & (cmd_op == OP_HALT);
    assign cmd_run   = cmd_valid & (cmd_op == OP_RUN);
    assign cmd_step  = cmd_valid & (cmd_op == OP_STEP);
    assign cmd_run_n = cmd_valid & (cmd_op == OP_RUN_N);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        steps_d = steps_q;
        skip_d  = skip_q;
        evt_d   = 1'b0;
        err_d   = 1'b0;

        if (core_en) begin
            skip_d = 1'b0;
        end

        if (state_q == S_HALTED) begin
            if (cmd_run) begin
                state_d = S_RUNNING;
                skip_d  = 1'b1;
            end else if (cmd_step) begin
                state_d = S_STEPPING;
                skip_d  = 1'b1;
            end else if (cmd_run_n) begin
                skip_d = 1'b1;
                if (cmd_arg == '0) begin
                    // Zero-length run completes immediately; report it like a finished count.
                    cause_d = CAUSE_DONE;
                    evt_d   = 1'b1;
                end else begin
                    steps_d = cmd_arg;
                    state_d = S_COUNTING;
                end
            end
        end else begin
            err_d = cmd_run | cmd_step | cmd_run_n;

            if (state_q == S_COUNTING && core_en) begin
                steps_d = steps_q - CNT_W'(1);
            end

            // Priority: EBREAK > breakpoint > HALT command > step/count done.
            if (stop) begin
                state_d = S_HALTED;
                cause_d = is_ebreak ? CAUSE_EBRK : CAUSE_BP;
            end else if (cmd_halt) begin
                state_d = S_HALTED;
                cause_d = CAUSE_CMD;
            end else if (state_q == S_STEPPING) begin
                state_d = S_HALTED;
                cause_d = CAUSE_DONE;
            end else if (state_q == S_COUNTING && steps_q == CNT_W'(1)) begin
                state_d = S_HALTED;
                cause_d = CAUSE_DONE;
            end

            evt_d = (state_d == S_HALTED);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= RESET_STATE;
            cause_q   <= CAUSE_CMD;
            steps_q   <= '0;
            skip_q    <= 1'b0;
            evt_q     <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            steps_q <= steps_d;
            skip_q  <= skip_d;
            evt_q   <= evt_d;
            err_q   <= err_d;
            if (core_en) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign cmd_ready  = 1'b1;
    assign cmd_err    = err_q;
    assign state      = state_q;
    assign halt_cause = cause_q;
    assign halt_evt   = evt_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: two instances (leave reset halted / running), each fed by a
// tiny core model whose PC advances by 4 on every retire and whose instruction is ADDI
// everywhere except a movable EBREAK address.
module tb_core_run_ctrl;

    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] ADDI = 32'h0010_8093;
    localparam logic [31:0] EF   = 32'hFFFF_FF00;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_arg = 16'd0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] eb_addr = EF;

    logic [31:0] pc_b, pc_a, instr_b, instr_a;
    logic        rdy_b, err_b, en_b, evt_b;
    logic [1:0]  st_b, cause_b;
    logic [31:0] ret_b;
    logic        rdy_a, err_a, en_a, evt_a;
    logic [1:0]  st_a, cause_a;
    logic [31:0] ret_a;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign instr_b = (pc_b == eb_addr) ? EBRK : ADDI;
    assign instr_a = (pc_a == eb_addr) ? EBRK : ADDI;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_b <= 32'd0;
            pc_a <= 32'd0;
        end else begin
            if (en_b) pc_b <= pc_b + 32'd4;
            if (en_a) pc_a <= pc_a + 32'd4;
        end
    end

    core_run_ctrl #(.RESET_RUN(1'b0), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .cmd_ready(rdy_b), .cmd_err(err_b), .PC(pc_b), .Instr(instr_b),
        .bp_en(bp_en), .bp_addr(bp_addr), .core_en(en_b), .state(st_b),
        .halt_cause(cause_b), .halt_evt(evt_b), .retired(ret_b)
    );

    core_run_ctrl #(.RESET_RUN(1'b1), .CNT_W(16)) dut_r (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .cmd_ready(rdy_a), .cmd_err(err_a), .PC(pc_a), .Instr(instr_a),
        .bp_en(bp_en), .bp_addr(bp_addr), .core_en(en_a), .state(st_a),
        .halt_cause(cause_a), .halt_evt(evt_a), .retired(ret_a)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] arg;
        logic        bpen;
        logic [31:0] bpaddr;
        logic [31:0] ebaddr;
        int          cyc;
        logic [1:0]  st;
        logic [1:0]  cause;
        logic [31:0] pc;
        logic [31:0] ret;
        int          evts;
        int          errs;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(logic [1:0] op, logic [15:0] arg, logic bpen,
                                logic [31:0] bpaddr, logic [31:0] ebaddr, int cyc,
                                logic [1:0] st, logic [1:0] cause, logic [31:0] pc,
                                logic [31:0] ret, int evts, int errs);
        vec_t v;
        v.op = op; v.arg = arg; v.bpen = bpen; v.bpaddr = bpaddr; v.ebaddr = ebaddr;
        v.cyc = cyc; v.st = st; v.cause = cause; v.pc = pc; v.ret = ret;
        v.evts = evts; v.errs = errs;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command at a negedge, then watch a fixed window of cycles.
    task automatic apply(input vec_t v, input int idx);
        int evts;
        int errs;
        evts = 0;
        errs = 0;
        bp_en     = v.bpen;
        bp_addr   = v.bpaddr;
        eb_addr   = v.ebaddr;
        cmd_op    = v.op;
        cmd_arg   = v.arg;
        cmd_valid = 1'b1;
        for (int c = 0; c < v.cyc; c++) begin
            @(negedge CLK);
            if (evt_b) evts++;
            if (err_b) errs++;
            cmd_valid = 1'b0;
        end
        check($sformatf("v%0d state", idx), {30'd0, st_b}, {30'd0, v.st});
        check($sformatf("v%0d cause", idx), {30'd0, cause_b}, {30'd0, v.cause});
        check($sformatf("v%0d pc", idx), pc_b, v.pc);
        check($sformatf("v%0d retired", idx), ret_b, v.ret);
        check($sformatf("v%0d halt_evt_count", idx), evts, v.evts);
        check($sformatf("v%0d cmd_err_count", idx), errs, v.errs);
    endtask

    initial begin
        int evts;
        //         op    arg    bp    bpaddr  eb     cyc st  cause pc        ret  ev er
        vt[0]  = mk(2'd2, 16'd0, 1'b0, 32'h0,  EF,    4, 2'd0, 2'd1, 32'h04, 32'd1,  1, 0);
        vt[1]  = mk(2'd2, 16'd0, 1'b0, 32'h0,  EF,    4, 2'd0, 2'd1, 32'h08, 32'd2,  1, 0);
        vt[2]  = mk(2'd2, 16'd0, 1'b0, 32'h0,  EF,    4, 2'd0, 2'd1, 32'h0C, 32'd3,  1, 0);
        vt[3]  = mk(2'd3, 16'd5, 1'b0, 32'h0,  EF,    8, 2'd0, 2'd1, 32'h20, 32'd8,  1, 0);
        vt[4]  = mk(2'd3, 16'd0, 1'b0, 32'h0,  EF,    3, 2'd0, 2'd1, 32'h20, 32'd8,  1, 0);
        vt[5]  = mk(2'd1, 16'd0, 1'b1, 32'h30, EF,    9, 2'd0, 2'd2, 32'h30, 32'd12, 1, 0);
        vt[6]  = mk(2'd3, 16'd0, 1'b1, 32'h30, EF,    3, 2'd0, 2'd1, 32'h30, 32'd12, 1, 0);
        vt[7]  = mk(2'd3, 16'd3, 1'b1, 32'h30, EF,    6, 2'd0, 2'd1, 32'h3C, 32'd15, 1, 0);
        vt[8]  = mk(2'd1, 16'd0, 1'b1, 32'h44, 32'h44, 6, 2'd0, 2'd3, 32'h44, 32'd17, 1, 0);
        vt[9]  = mk(2'd2, 16'd0, 1'b1, 32'h44, 32'h44, 4, 2'd0, 2'd1, 32'h48, 32'd18, 1, 0);
        vt[10] = mk(2'd1, 16'd0, 1'b0, 32'h0,  EF,    6, 2'd1, 2'd1, 32'h5C, 32'd23, 0, 0);
        vt[11] = mk(2'd1, 16'd0, 1'b0, 32'h0,  EF,    3, 2'd1, 2'd1, 32'h68, 32'd26, 0, 1);
        vt[12] = mk(2'd0, 16'd0, 1'b0, 32'h0,  EF,    3, 2'd0, 2'd0, 32'h6C, 32'd27, 1, 0);
        vt[13] = mk(2'd0, 16'd0, 1'b0, 32'h0,  EF,    3, 2'd0, 2'd0, 32'h6C, 32'd27, 0, 0);

        // Reset values on both instances.
        repeat (2) @(negedge CLK);
        check("rst state", {30'd0, st_b}, 32'd0);
        check("rst cause", {30'd0, cause_b}, 32'd0);
        check("rst retired", ret_b, 32'd0);
        check("rst halt_evt", {31'd0, evt_b}, 32'd0);
        check("rst cmd_err", {31'd0, err_b}, 32'd0);
        check("rst core_en", {31'd0, en_b}, 32'd0);
        check("rst cmd_ready", {31'd0, rdy_b}, 32'd1);
        check("rst_run state", {30'd0, st_a}, 32'd1);
        check("rst_run retired", ret_a, 32'd0);

        // RESET_RUN=1: retiring from the very first edge after reset release.
        RST = 1'b1;
        #1;
        check("run_from_reset core_en", {31'd0, en_a}, 32'd1);
        repeat (2) @(negedge CLK);
        check("run_from_reset retired", ret_a, 32'd2);
        check("run_from_reset pc", pc_a, 32'h8);

        for (int i = 0; i < 14; i++) begin
            apply(vt[i], i);
        end

        // HALT arriving on the same edge that the count completes: HALT cause wins.
        evts = 0;
        cmd_op = 2'd3; cmd_arg = 16'd2; cmd_valid = 1'b1;
        @(negedge CLK); cmd_valid = 1'b0;
        @(negedge CLK); cmd_op = 2'd0; cmd_valid = 1'b1;
        @(negedge CLK); cmd_valid = 1'b0;
        if (evt_b) evts++;
        @(negedge CLK);
        if (evt_b) evts++;
        check("halt_at_done state", {30'd0, st_b}, 32'd0);
        check("halt_at_done cause", {30'd0, cause_b}, 32'd0);
        check("halt_at_done retired", ret_b, 32'd29);
        check("halt_at_done pc", pc_b, 32'h74);
        check("halt_at_done evt", evts, 32'd1);

        // Reset in the middle of COUNTING.
        cmd_op = 2'd3; cmd_arg = 16'd10; cmd_valid = 1'b1;
        @(negedge CLK); cmd_valid = 1'b0;
        repeat (2) @(negedge CLK);
        check("mid_count state", {30'd0, st_b}, 32'd3);
        check("mid_count retired", ret_b, 32'd31);
        RST = 1'b0;
        #1;
        check("mid_rst state", {30'd0, st_b}, 32'd0);
        check("mid_rst cause", {30'd0, cause_b}, 32'd0);
        check("mid_rst retired", ret_b, 32'd0);
        check("mid_rst halt_evt", {31'd0, evt_b}, 32'd0);
        check("mid_rst cmd_err", {31'd0, err_b}, 32'd0);
        check("mid_rst core_en", {31'd0, en_b}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        // From reset: breakpoint at 0x10 halts with 4 retired, then resume runs past it.
        apply(mk(2'd1, 16'd0, 1'b1, 32'h10, EF, 9, 2'd0, 2'd2, 32'h10, 32'd4, 1, 0), 100);
        apply(mk(2'd1, 16'd0, 1'b1, 32'h10, EF, 4, 2'd1, 2'd2, 32'h1C, 32'd7, 0, 0), 101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
